// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG byte stuffer: FSM states, marker
// bytes and the layout of one buffered input word.
package jpeg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    STUFF,
    EOI_FF,
    EOI_D9,
    DONE
  } jpeg_state_e;

  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] EOI_LO     = 8'hD9;

  typedef struct packed {
    logic        last;
    logic [5:0]  nbits;
    logic [31:0] word;
  } jpeg_entry_t;

  // Out-of-range valid-bit counts mean "whole word".
  function automatic logic [5:0] norm_nbits(input logic [5:0] n);
    return (n == 6'd0 || n > 6'd32) ? 6'd32 : n;
  endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// First-word-fall-through FIFO; rdata shows the head entry whenever empty=0.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module jpeg_word_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Turns 32-bit entropy-coded words into a JPEG byte stream: 0x00 after every
// data 0xFF, 1-padding of the final partial byte, optional EOI marker.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit EMIT_EOI   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] JPEG_bitstream,
  input  logic        data_ready,
  input  logic        last,
  input  logic [5:0]  last_nbits,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  // Output handshake: byte_out is transferred on a rising edge where
  // byte_valid=1 and byte_ready=1; while valid and not ready, the byte holds.

  localparam int ENTRY_W = $bits(jpeg_entry_t);

  jpeg_state_e state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        overflow_q, overflow_d;

  jpeg_entry_t wr_entry, head;
  logic        fifo_full, fifo_empty, pop;
  logic [5:0]  head_nbits;
  logic [2:0]  head_cnt;
  logic [31:0] head_word;
  logic [31:0] cur_word;
  logic [2:0]  cur_cnt;
  logic        cur_last;

  assign wr_entry = '{last: last, nbits: last_nbits, word: JPEG_bitstream};

  jpeg_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (data_ready),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head decode: byte count and 1-padding below the valid bits of a last word.
  always_comb begin
    head_nbits = norm_nbits(head.nbits);
    head_cnt   = head.last ? 3'((head_nbits + 6'd7) >> 3) : 3'd4;
    head_word  = head.last ? (head.word | (32'hFFFF_FFFF >> head_nbits)) : head.word;
  end

  function automatic jpeg_state_e word_end_state(input logic is_last, input logic pending);
    if (is_last) return EMIT_EOI ? EOI_FF : DONE;
    return pending ? LOAD : IDLE;
  endfunction

  // LOAD presents the head's first byte straight from the FIFO and pops only
  // when that byte is accepted, so the next word follows with no bubble.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_out   = STUFF_BYTE;
    frame_done = 1'b0;
    cur_word   = word_q;
    cur_cnt    = cnt_q;
    cur_last   = last_q;
    if (state_q == LOAD) begin
      cur_word = head_word;
      cur_cnt  = head_cnt;
      cur_last = head.last;
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD, EMIT: begin
        byte_valid = 1'b1;
        byte_out   = cur_word[31:24];
        if (byte_ready) begin
          pop    = (state_q == LOAD);
          word_d = {cur_word[23:0], 8'h00};
          cnt_d  = cur_cnt - 3'd1;
          last_d = cur_last;
          if (cur_word[31:24] == MARKER_FF) state_d = STUFF;
          else if (cnt_d == 3'd0)           state_d = word_end_state(cur_last, !fifo_empty);
          else                              state_d = EMIT;
        end
      end
      STUFF: begin
        byte_valid = 1'b1;
        byte_out   = STUFF_BYTE;
        if (byte_ready) begin
          if (cnt_q == 3'd0) state_d = word_end_state(last_q, !fifo_empty);
          else               state_d = EMIT;
        end
      end
      EOI_FF: begin
        byte_valid = 1'b1;
        byte_out   = MARKER_FF;
        if (byte_ready) state_d = EOI_D9;
      end
      EOI_D9: begin
        byte_valid = 1'b1;
        byte_out   = EOI_LO;
        if (byte_ready) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overflow_d = overflow_q | (data_ready & fifo_full & ~pop);
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Self-checking bench for jpeg_byte_stuffer: expected bytes are queued as
// words are driven and compared against bytes captured at the output.
module tb_jpeg_byte_stuffer;
  import jpeg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] JPEG_bitstream;
  logic        data_ready, last, byte_ready;
  logic [5:0]  last_nbits;
  logic [7:0]  byte_out;
  logic        byte_valid, frame_done, overflow;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_valid_cyc = -1;
  int done_pulses = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];

  jpeg_byte_stuffer #(.FIFO_DEPTH(4), .EMIT_EOI(1'b1)) dut (
    .clk(clk), .rst(rst), .JPEG_bitstream(JPEG_bitstream), .data_ready(data_ready),
    .last(last), .last_nbits(last_nbits), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .frame_done(frame_done), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter / monitor (samples on the falling edge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (rst && byte_valid && byte_ready) begin
      got_q.push_back(byte_out);
      got_cyc_q.push_back(cyc);
    end
    if (rst && frame_done) done_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: expected stuffed bytes for one word
  function automatic void model_push(input logic [31:0] w, input logic l, input logic [5:0] nb);
    int n, cnt;
    logic [7:0] b;
    n   = (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
    cnt = l ? (n + 7) / 8 : 4;
    for (int i = 0; i < cnt; i++) begin
      b = w[31 - 8*i -: 8];
      if (l && i == cnt - 1)
        for (int k = 0; k < 8; k++) if (8*i + k >= n) b[7-k] = 1'b1;
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
    if (l) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD9);
    end
  endfunction

  // driver tasks (called just after a rising edge)
  task automatic drive_word(input logic [31:0] w, input logic l, input logic [5:0] nb);
    JPEG_bitstream = w; data_ready = 1'b1; last = l; last_nbits = nb;
    @(posedge clk); #1;
    data_ready = 1'b0; last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; data_ready = 1'b0; last = 1'b0; last_nbits = '0;
    JPEG_bitstream = '0; byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete(); got_cyc_q.delete(); done_pulses = 0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int i = 0;
    while (got_q.size() < exp_q.size() && i < budget) begin
      @(posedge clk); #1; i++;
    end
    repeat (4) begin @(posedge clk); #1; end
    ok = (got_q.size() == exp_q.size());
  endtask

  task automatic test_reset();
    logic [7:0] e, g;
    rst = 1'b0; data_ready = 1'b0; last = 1'b0; last_nbits = '0;
    JPEG_bitstream = '0; byte_ready = 1'b1;
    #2;
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", byte_valid); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h, required 00", byte_out); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE); end
    do_reset();
  endtask

  task automatic test_basic_word();
    bit ok; int n; logic [7:0] e, g;
    do_reset();
    first_valid_cyc = -1;
    n = cyc;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    drive_word(32'h1234_5678, 1'b0, 6'd0);
    wait_drain(50, ok);
    n_checks++; if (first_valid_cyc != n + 2) begin n_fail++; $display("FAIL basic_latency: got cycle %0d, required %0d", first_valid_cyc, n + 2); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %h, required %h", g, e); end
    end
    n_checks++; if (done_pulses != 0) begin n_fail++; $display("FAIL basic_no_done: got %0d pulses, required 0", done_pulses); end
  endtask

  task automatic test_stuffing();
    bit ok; logic [7:0] e, g;
    logic [7:0] tbl [6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
    do_reset();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    drive_word(32'hFF00_FFAB, 1'b0, 6'd0);
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stuff_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL stuff_byte: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_last_eoi();
    bit ok; logic [7:0] e, g;
    do_reset();
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCF); exp_q.push_back(8'hFF); exp_q.push_back(8'hD9);
    drive_word(32'hABC0_0000, 1'b1, 6'd12);
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL eoi_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL eoi_byte: got %h, required %h", g, e); end
    end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL eoi_done: got %0d pulse cycles, required 1", done_pulses); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL eoi_idle: got state %0d, required %0d", dbg_state, IDLE); end
  endtask

  task automatic test_last_padding();
    bit ok; logic [7:0] e, g;
    logic [31:0] words [4] = '{32'hFFF0_0000, 32'h1122_3344, 32'h5566_7788, 32'h8000_0000};
    logic [5:0]  nbits [4] = '{6'd12, 6'd0, 6'd40, 6'd1};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      model_push(words[t], 1'b1, nbits[t]);
      drive_word(words[t], 1'b1, nbits[t]);
      wait_drain(60, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL pad_count[%0d]: got %0d bytes, required %0d", t, got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL pad_byte[%0d]: got %h, required %h", t, g, e); end
      end
      n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL pad_done[%0d]: got %0d, required 1", t, done_pulses); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int i; logic [7:0] held, e, g;
    do_reset();
    model_push(32'hA1B2_C3D4, 1'b0, 6'd0);
    drive_word(32'hA1B2_C3D4, 1'b0, 6'd0);
    i = 0;
    while (got_q.size() < 1 && i < 50) begin @(posedge clk); #1; i++; end
    byte_ready = 1'b0;
    held = byte_out;
    n_checks++; if (held !== 8'hB2) begin n_fail++; $display("FAIL bp_held: got %h, required b2", held); end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (byte_valid !== 1'b1 || byte_out !== 8'hB2) begin
        n_fail++; $display("FAIL bp_stable: got valid=%b byte=%h, required valid=1 byte=b2", byte_valid, byte_out);
      end
    end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_byte: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_overflow();
    bit ok; logic [7:0] e, g;
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) model_push(32'h1020_3040 + i, 1'b0, 6'd0);
      drive_word(32'h1020_3040 + i, 1'b0, 6'd0);
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    byte_ready = 1'b1;
    wait_drain(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL ovf_byte: got %h, required %h", g, e); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    bit ok; logic [7:0] e, g;
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_push(32'h2122_2324 + (i << 24), 1'b0, 6'd0);
      drive_word(32'h2122_2324 + (i << 24), 1'b0, 6'd0);
    end
    byte_ready = 1'b1;
    model_push(32'h5A5B_5C5D, 1'b0, 6'd0);
    drive_word(32'h5A5B_5C5D, 1'b0, 6'd0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b, required 0", overflow); end
    wait_drain(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fpp_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL fpp_byte: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int span; logic [7:0] e, g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      model_push(32'h3132_3334 + (i << 4), 1'b0, 6'd0);
      drive_word(32'h3132_3334 + (i << 4), 1'b0, 6'd0);
    end
    wait_drain(60, ok);
    span = (got_cyc_q.size() == 12) ? got_cyc_q[11] - got_cyc_q[0] : -1;
    n_checks++; if (span != 11) begin n_fail++; $display("FAIL b2b_span: got %0d cycles for 12 bytes, required 11", span); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int i; logic [7:0] e, g;
    do_reset();
    for (int k = 0; k < 3; k++) drive_word(32'h4142_4344 + (k << 8), 1'b0, 6'd0);
    i = 0;
    while (got_q.size() < 5 && i < 50) begin @(posedge clk); #1; i++; end
    rst = 1'b0;
    #1;
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid_drop: got %b, required 0", byte_valid); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL rmf_byte_zero: got %h, required 00", byte_out); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_first_edge: got valid %b, required 0", byte_valid); end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    drive_word(32'h0102_0304, 1'b0, 6'd0);
    wait_drain(50, ok);
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmf_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rmf_byte: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_random();
    bit ok; logic [31:0] w; logic [5:0] nb; logic [7:0] e, g;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      done_pulses = 0;
      for (int k = 0; k < 4; k++) begin
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[15:8] = 8'hFF;
        nb = 6'($urandom_range(0, 63));
        model_push(w, k == 3, nb);
        byte_ready = 1'($urandom_range(0, 1));
        drive_word(w, k == 3, nb);
      end
      for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) begin
        byte_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      byte_ready = 1'b1;
      wait_drain(50, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d bytes, required %0d", it, got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h, required %h", it, g, e); end
      end
      exp_q.delete(); got_q.delete();
      n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL rand_done[%0d]: got %0d, required 1", it, done_pulses); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_stuffing();
    test_last_eoi();
    test_last_padding();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the input word buffer depth in 32-bit words (power of two, at least 2).
REQ-002 Parameter EMIT_EOI, default 1, SHALL append the EOI marker (0xFF 0xD9) after the last word when set to 1.
REQ-003 clk  in  1  SHALL be the single clock; all state is on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 JPEG_bitstream  in  32  SHALL carry entropy-coded data, MSB-first.
REQ-006 data_ready  in  1  SHALL qualify JPEG_bitstream for one cycle per word.
REQ-007 last  in  1  SHALL mark, together with data_ready, the final word of a frame.
REQ-008 last_nbits  in  6  SHALL give the valid MSB bit count (1..32) of the last word; it is ignored unless last=1.
REQ-009 byte_out  out  8  SHALL be the stuffed output byte.
REQ-010 byte_valid  out  1  SHALL indicate that byte_out is valid.
REQ-011 byte_ready  in  1  SHALL be the downstream accept; a transfer occurs when byte_valid=1 and byte_ready=1.
REQ-012 frame_done  out  1  SHALL pulse for one cycle when a frame completes.
REQ-013 overflow  out  1  SHALL be a sticky flag set when a word is dropped.

Function
REQ-014 Words SHALL be written to the buffer on the edge where data_ready=1 and the buffer is not full; the stored entry is {last, last_nbits, word}.
REQ-015 A write while the buffer is full SHALL drop the word and set overflow=1 until reset.
REQ-016 The FSM SHALL have the states IDLE, LOAD, EMIT, STUFF, EOI_FF, EOI_D9 and DONE.
REQ-017 IDLE→LOAD SHALL occur when the buffer is non-empty; LOAD SHALL pop one entry and set the byte count to 4, or to ceil(last_nbits/8) when last=1.
REQ-018 EMIT SHALL present bytes MSB-first; the remaining byte count SHALL decrement on each transfer.
REQ-019 After a transferred byte equal to 0xFF, the FSM SHALL enter STUFF, present 0x00, and return to EMIT once it is accepted.
REQ-020 When the count reaches 0, the FSM SHALL go to LOAD if a word is pending, else to IDLE; this holds whenever last=0.
REQ-021 Latency: with the buffer empty, the FSM in IDLE and byte_ready=1, byte_valid SHALL first assert in cycle N+2, where N is the data_ready cycle.
REQ-022 Sustained throughput SHALL be 1 byte per cycle; LOAD SHALL overlap the final EMIT transfer so there are no bubbles between words.
REQ-023 In the last word, bit positions below last_nbits within the final byte SHALL be padded with 1s; a padded byte equal to 0xFF SHALL be stuffed.
REQ-024 After the last word, the FSM SHALL go to EOI_FF then EOI_D9 when EMIT_EOI=1, else directly to DONE; marker bytes SHALL NOT be stuffed.
REQ-025 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-026 Words arriving after last SHALL be buffered and processed as the next frame after DONE.
REQ-027 While byte_valid=1 and byte_ready=0, byte_out SHALL stay stable and byte_valid SHALL stay high.
REQ-028 A simultaneous buffer push and pop SHALL be legal when the buffer is full; the push SHALL succeed.
REQ-029 last_nbits values of 0 or above 32 SHALL be treated as 32.

Reset
REQ-030 When rst is low, the FSM SHALL enter IDLE, the buffer SHALL become empty, and byte_out=0x00, byte_valid=0, frame_done=0 and overflow=0, all asynchronously.
REQ-031 A reset asserted mid-frame SHALL discard the partial word and all buffered words; no byte SHALL be emitted on the first edge after release.

Structure
REQ-032 jpeg_pkg SHALL hold the FSM state enum, the constants MARKER_FF (0xFF), STUFF_BYTE (0x00) and EOI_LO (0xD9), and the buffer entry typedef.
REQ-033 The buffer SHALL be a sub-module named jpeg_word_fifo (synchronous, parameterised width and depth, full/empty outputs, first-word-fall-through).

Verification
REQ-034 Word 0x12345678, last=0, byte_ready=1 SHALL produce the bytes 12,34,56,78, with the first byte_valid in cycle N+2.
REQ-035 Word 0xFF00FFAB SHALL produce FF,00,00,FF,00,AB.
REQ-036 Word 0xABC00000 with last=1, last_nbits=12 and EMIT_EOI=1 SHALL produce AB,CF,FF,D9, then a single-cycle frame_done.
REQ-037 Holding byte_ready low for 3 cycles mid-word SHALL keep byte_out unchanged and byte_valid high, with no byte lost or duplicated.
REQ-038 Six back-to-back words with byte_ready=0 and FIFO_DEPTH=4 SHALL store 4 words and leave overflow=1; only those 4 words' bytes SHALL emerge afterwards.
REQ-039 Driving rst low during EMIT of word 2 of 3 SHALL immediately drop byte_valid; after release, a new word 0x01020304 SHALL produce 01,02,03,04 only.
